// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data access.
// Contention alternates priority, and a watchdog aborts hung transactions.
module mem_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic [DW-1:0] if_rdata,
   output logic          if_ready,
   input  logic          dm_req,
   input  logic          dm_we,
   input  logic [AW-1:0] dm_addr,
   input  logic [DW-1:0] dm_wdata,
   output logic [DW-1:0] dm_rdata,
   output logic          dm_ready,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ready,
   output logic          stall_f,
   output logic          stall_m,
   output logic          bus_err
);
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {IDLE, FETCH, DATA} stateType;
   typedef enum logic {GRANT_FETCH, GRANT_DATA} grantType;

   stateType      state, nextState;
   grantType      lastGrant, nextLastGrant;
   logic [AW-1:0] addrReg, nextAddr;
   logic [DW-1:0] wdataReg, nextWdata;
   logic          weReg, nextWe;
   logic [CW-1:0] waitCnt, nextWaitCnt;
   logic          busErrReg;
   logic          active, timeoutHit, finish, grantFetch, grantData;

   assign active     = (state != IDLE);
   // waitCnt counts cycles already waited, so the TIMEOUT-th empty cycle aborts.
   assign timeoutHit = active & ~mem_ready & (waitCnt == CW'(TIMEOUT - 1));
   assign finish     = active & (mem_ready | timeoutHit);

   assign mem_req   = active;
   assign mem_we    = (state == DATA) & weReg;
   assign mem_addr  = addrReg;
   assign mem_wdata = wdataReg;

   assign if_ready  = finish & (state == FETCH);
   assign dm_ready  = finish & (state == DATA);
   assign if_rdata  = (if_ready & mem_ready) ? mem_rdata : '0;
   assign dm_rdata  = (dm_ready & mem_ready) ? mem_rdata : '0;

   assign stall_f   = if_req & ~if_ready;
   assign stall_m   = dm_req & ~dm_ready;
   assign bus_err   = busErrReg;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path infers a latch.
      nextState     = state;
      nextLastGrant = lastGrant;
      nextAddr      = addrReg;
      nextWdata     = wdataReg;
      nextWe        = weReg;
      nextWaitCnt   = waitCnt;
      grantFetch    = 1'b0;
      grantData     = 1'b0;

      case (state)
         IDLE: begin
            if (dm_req && (!if_req || lastGrant == GRANT_FETCH)) grantData = 1'b1;
            else if (if_req)                                     grantFetch = 1'b1;
         end
         FETCH: begin
            if (finish) begin
               if (dm_req) grantData = 1'b1;
               else        nextState = IDLE;
            end else begin
               nextWaitCnt = waitCnt + CW'(1);
            end
         end
         DATA: begin
            // The finishing requester's own req is stale here, so only the other may win.
            if (finish) begin
               if (if_req) grantFetch = 1'b1;
               else        nextState  = IDLE;
            end else begin
               nextWaitCnt = waitCnt + CW'(1);
            end
         end
         default: nextState = IDLE;
      endcase

      if (grantData) begin
         nextState     = DATA;
         nextLastGrant = GRANT_DATA;
         nextAddr      = dm_addr;
         nextWdata     = dm_wdata;
         nextWe        = dm_we;
         nextWaitCnt   = '0;
      end else if (grantFetch) begin
         nextState     = FETCH;
         nextLastGrant = GRANT_FETCH;
         nextAddr      = if_addr;
         nextWdata     = '0;
         nextWe        = 1'b0;
         nextWaitCnt   = '0;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         lastGrant <= GRANT_FETCH;
         addrReg   <= '0;
         wdataReg  <= '0;
         weReg     <= 1'b0;
         waitCnt   <= '0;
         busErrReg <= 1'b0;
      end else begin
         state     <= nextState;
         lastGrant <= nextLastGrant;
         addrReg   <= nextAddr;
         wdataReg  <= nextWdata;
         weReg     <= nextWe;
         waitCnt   <= nextWaitCnt;
         if (timeoutHit) busErrReg <= 1'b1;
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// scored against a transaction-level model with its own backing memory.
module tb_mem_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic [DW-1:0] if_rdata;
   logic          if_ready;
   logic          dm_req;
   logic          dm_we;
   logic [AW-1:0] dm_addr;
   logic [DW-1:0] dm_wdata;
   logic [DW-1:0] dm_rdata;
   logic          dm_ready;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_ready;
   logic          stall_f;
   logic          stall_m;
   logic          bus_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata), .dm_ready(dm_ready),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .stall_f(stall_f), .stall_m(stall_m), .bus_err(bus_err)
   );

   task automatic idleInputs();
      if_req = 1'b0; if_addr = '0;
      dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
      mem_rdata = '0; mem_ready = 1'b0;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      idleInputs();
      reset = 1'b0;
      if_req = 1'b1; dm_req = 1'b1; mem_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req: got %b expected 0", mem_req); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we: got %b expected 0", mem_we); end
      checks++; if (mem_addr !== '0) begin errors++; $display("FAIL rst_mem_addr: got %h expected 0", mem_addr); end
      checks++; if (mem_wdata !== '0) begin errors++; $display("FAIL rst_mem_wdata: got %h expected 0", mem_wdata); end
      checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL rst_bus_err: got %b expected 0", bus_err); end
      checks++; if ({if_ready, dm_ready} !== 2'b00) begin errors++; $display("FAIL rst_ready: got %b expected 00", {if_ready, dm_ready}); end
      idleInputs();
      reset = 1'b1;
   endtask

   task automatic test_fetch_only();
      nextCycle();
      if_req = 1'b1; if_addr = 32'h0000_0040; mem_ready = 1'b1; mem_rdata = 32'h2008_0005;
      @(negedge clk);
      checks++; if (stall_f !== 1'b1) begin errors++; $display("FAIL fetch_stall_c0: got %b expected 1", stall_f); end
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL fetch_req_c0: got %b expected 0", mem_req); end
      nextCycle();
      @(negedge clk);
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL fetch_req_c1: got %b expected 1", mem_req); end
      checks++; if (mem_addr !== 32'h40) begin errors++; $display("FAIL fetch_addr_c1: got %h expected 40", mem_addr); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL fetch_we_c1: got %b expected 0", mem_we); end
      checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL fetch_ready_c1: got %b expected 1", if_ready); end
      checks++; if (if_rdata !== 32'h2008_0005) begin errors++; $display("FAIL fetch_rdata_c1: got %h expected 20080005", if_rdata); end
      checks++; if (stall_f !== 1'b0) begin errors++; $display("FAIL fetch_stall_c1: got %b expected 0", stall_f); end
      nextCycle();
      @(negedge clk);
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL fetch_idle_c2: got %b expected 0", mem_req); end
      checks++; if (if_ready !== 1'b0 || if_rdata !== '0) begin errors++; $display("FAIL fetch_noready_c2: got %b/%h expected 0/0", if_ready, if_rdata); end
      if_req = 1'b0; mem_ready = 1'b0;
   endtask

   task automatic test_store();
      logic expReq, expReady;
      nextCycle();
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h54; dm_wdata = 32'h7; mem_rdata = 32'h1234_5678;
      for (int cyc = 0; cyc <= 5; cyc++) begin
         mem_ready = (cyc == 4);
         @(negedge clk);
         expReq   = (cyc >= 1 && cyc <= 4);
         expReady = (cyc == 4);
         checks++; if (mem_req !== expReq) begin errors++; $display("FAIL store_req c%0d: got %b expected %b", cyc, mem_req, expReq); end
         checks++; if (mem_we !== expReq) begin errors++; $display("FAIL store_we c%0d: got %b expected %b", cyc, mem_we, expReq); end
         checks++; if (dm_ready !== expReady) begin errors++; $display("FAIL store_ready c%0d: got %b expected %b", cyc, dm_ready, expReady); end
         checks++; if (stall_m !== (cyc < 4)) begin errors++; $display("FAIL store_stall c%0d: got %b expected %b", cyc, stall_m, cyc < 4); end
         checks++; if (dm_rdata !== (expReady ? 32'h1234_5678 : 32'h0)) begin errors++; $display("FAIL store_rdata c%0d: got %h", cyc, dm_rdata); end
         if (expReq) begin
            checks++; if (mem_addr !== 32'h54 || mem_wdata !== 32'h7) begin errors++; $display("FAIL store_bus c%0d: got %h/%h expected 54/7", cyc, mem_addr, mem_wdata); end
         end
         if (cyc == 4) dm_req = 1'b0;
         nextCycle();
      end
      checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL store_no_err: got %b expected 0", bus_err); end
      idleInputs();
   endtask

   task automatic test_contention();
      @(negedge clk) reset = 1'b0;
      @(negedge clk) reset = 1'b1;
      nextCycle();
      if_req = 1'b1; if_addr = 32'h200; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
      mem_ready = 1'b1; mem_rdata = 32'hA5A5_0001;
      @(negedge clk);
      checks++; if ({stall_f, stall_m, mem_req} !== 3'b110) begin errors++; $display("FAIL cont_c0: got %b expected 110", {stall_f, stall_m, mem_req}); end
      nextCycle();
      @(negedge clk);
      checks++; if (mem_addr !== 32'h300 || mem_we !== 1'b0) begin errors++; $display("FAIL cont_data_first: got %h/%b expected 300/0", mem_addr, mem_we); end
      checks++; if ({dm_ready, if_ready} !== 2'b10) begin errors++; $display("FAIL cont_ready_c1: got %b expected 10", {dm_ready, if_ready}); end
      checks++; if (dm_rdata !== 32'hA5A5_0001 || if_rdata !== '0) begin errors++; $display("FAIL cont_rdata_c1: got %h/%h", dm_rdata, if_rdata); end
      checks++; if (stall_f !== 1'b1) begin errors++; $display("FAIL cont_stall_f_c1: got %b expected 1", stall_f); end
      nextCycle();
      dm_req = 1'b0; mem_rdata = 32'hA5A5_0002;
      @(negedge clk);
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h200) begin errors++; $display("FAIL cont_fetch_b2b: got %b/%h expected 1/200", mem_req, mem_addr); end
      checks++; if ({if_ready, dm_ready} !== 2'b10 || if_rdata !== 32'hA5A5_0002) begin errors++; $display("FAIL cont_ready_c2: got %b/%h", {if_ready, dm_ready}, if_rdata); end
      nextCycle();
      dm_req = 1'b1; dm_addr = 32'h304;
      @(negedge clk);
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL cont_idle_c3: got %b expected 0", mem_req); end
      nextCycle();
      @(negedge clk);
      checks++; if (mem_addr !== 32'h304 || {dm_ready, if_ready} !== 2'b10) begin errors++; $display("FAIL cont_alternate: got %h/%b expected 304/10", mem_addr, {dm_ready, if_ready}); end
      if_req = 1'b0; dm_req = 1'b0;
      nextCycle();
      idleInputs();
   endtask

   task automatic test_timeout();
      nextCycle();
      if_req = 1'b1; if_addr = 32'h100; mem_ready = 1'b0; mem_rdata = 32'hDEAD_BEEF;
      for (int cyc = 0; cyc <= 5; cyc++) begin
         @(negedge clk);
         checks++; if (mem_req !== (cyc >= 1 && cyc <= 4)) begin errors++; $display("FAIL to_req c%0d: got %b", cyc, mem_req); end
         checks++; if (if_ready !== (cyc == 4)) begin errors++; $display("FAIL to_ready c%0d: got %b expected %b", cyc, if_ready, cyc == 4); end
         checks++; if (if_rdata !== '0) begin errors++; $display("FAIL to_rdata c%0d: got %h expected 0", cyc, if_rdata); end
         checks++; if (bus_err !== (cyc == 5)) begin errors++; $display("FAIL to_err c%0d: got %b expected %b", cyc, bus_err, cyc == 5); end
         if (cyc == 4) if_req = 1'b0;
         nextCycle();
      end
      if_req = 1'b1; if_addr = 32'h104; mem_ready = 1'b1; mem_rdata = 32'h0BAD_F00D;
      nextCycle();
      @(negedge clk);
      checks++; if (if_ready !== 1'b1 || if_rdata !== 32'h0BAD_F00D) begin errors++; $display("FAIL to_after_ok: got %b/%h expected 1/0badf00d", if_ready, if_rdata); end
      checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b expected 1", bus_err); end
      if_req = 1'b0;
      nextCycle();
      @(negedge clk);
      checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL to_sticky_late: got %b expected 1", bus_err); end
      idleInputs();
   endtask

   task automatic test_reset_mid_load();
      nextCycle();
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h80; mem_ready = 1'b0;
      nextCycle();
      @(negedge clk);
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rml_active: got %b expected 1", mem_req); end
      #2 reset = 1'b0;
      #1;
      checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL rml_async: got %b/%b expected 0/0", mem_req, mem_we); end
      checks++; if (dm_ready !== 1'b0 || bus_err !== 1'b0) begin errors++; $display("FAIL rml_no_pulse: got %b/%b expected 0/0", dm_ready, bus_err); end
      nextCycle();
      checks++; if (dm_ready !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL rml_held: got %b/%b expected 0/0", dm_ready, mem_req); end
      @(negedge clk) reset = 1'b1;
      nextCycle();
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h80 || mem_we !== 1'b0) begin errors++; $display("FAIL rml_regrant: got %b/%h/%b expected 1/80/0", mem_req, mem_addr, mem_we); end
      @(negedge clk);
      mem_ready = 1'b1; mem_rdata = 32'h5555_AAAA;
      #1;
      checks++; if (dm_ready !== 1'b1 || dm_rdata !== 32'h5555_AAAA) begin errors++; $display("FAIL rml_done: got %b/%h expected 1/5555aaaa", dm_ready, dm_rdata); end
      nextCycle();
      idleInputs();
   endtask

   task automatic test_random(input int cycles);
      logic [DW-1:0] memArr [64];
      int            owner, last, waited, grant;
      bit            err, fin;
      logic [AW-1:0] txAddr, fAddr, dAddr;
      logic          txWe, fReq, dReq, dWe;
      logic [DW-1:0] txWdata, dWdata;
      logic          expIfReady, expDmReady;
      logic [DW-1:0] expIfRdata, expDmRdata;

      for (int i = 0; i < 64; i++) memArr[i] = $urandom();
      idleInputs();
      @(negedge clk) reset = 1'b0;
      @(negedge clk) reset = 1'b1;
      // owner/last: 0 = none, 1 = fetch, 2 = data
      owner = 0; last = 1; waited = 0; err = 1'b0;
      txAddr = '0; txWe = 1'b0; txWdata = '0;
      fReq = 1'b0; fAddr = '0; dReq = 1'b0; dWe = 1'b0; dAddr = '0; dWdata = '0;

      for (int c = 0; c < cycles; c++) begin
         nextCycle();
         if_req = fReq; if_addr = fAddr;
         dm_req = dReq; dm_we = dWe; dm_addr = dAddr; dm_wdata = dWdata;
         mem_ready = mem_req && ($urandom_range(0, 1) == 1);
         mem_rdata = mem_ready ? memArr[mem_addr[7:2]] : DW'($urandom());
         @(negedge clk);

         fin        = (owner != 0) && (mem_ready || waited + 1 == TO);
         expIfReady = fin && owner == 1;
         expDmReady = fin && owner == 2;
         expIfRdata = (expIfReady && mem_ready) ? memArr[txAddr[7:2]] : '0;
         expDmRdata = (expDmReady && mem_ready) ? memArr[txAddr[7:2]] : '0;

         checks++; if (mem_req !== (owner != 0)) begin errors++; $display("FAIL rnd_mem_req c%0d: got %b expected %b", c, mem_req, owner != 0); end
         if (owner != 0) begin
            checks++; if (mem_addr !== txAddr) begin errors++; $display("FAIL rnd_mem_addr c%0d: got %h expected %h", c, mem_addr, txAddr); end
            checks++; if (mem_we !== (owner == 2 && txWe)) begin errors++; $display("FAIL rnd_mem_we c%0d: got %b expected %b", c, mem_we, owner == 2 && txWe); end
            if (owner == 2 && txWe) begin
               checks++; if (mem_wdata !== txWdata) begin errors++; $display("FAIL rnd_mem_wdata c%0d: got %h expected %h", c, mem_wdata, txWdata); end
            end
         end
         checks++; if (if_ready !== expIfReady) begin errors++; $display("FAIL rnd_if_ready c%0d: got %b expected %b", c, if_ready, expIfReady); end
         checks++; if (dm_ready !== expDmReady) begin errors++; $display("FAIL rnd_dm_ready c%0d: got %b expected %b", c, dm_ready, expDmReady); end
         checks++; if (if_rdata !== expIfRdata) begin errors++; $display("FAIL rnd_if_rdata c%0d: got %h expected %h", c, if_rdata, expIfRdata); end
         checks++; if (dm_rdata !== expDmRdata) begin errors++; $display("FAIL rnd_dm_rdata c%0d: got %h expected %h", c, dm_rdata, expDmRdata); end
         checks++; if (stall_f !== (fReq && !expIfReady)) begin errors++; $display("FAIL rnd_stall_f c%0d: got %b", c, stall_f); end
         checks++; if (stall_m !== (dReq && !expDmReady)) begin errors++; $display("FAIL rnd_stall_m c%0d: got %b", c, stall_m); end
         checks++; if (bus_err !== err) begin errors++; $display("FAIL rnd_bus_err c%0d: got %b expected %b", c, bus_err, err); end

         if (fin && !mem_ready) err = 1'b1;
         if (fin && mem_ready && owner == 2 && txWe) memArr[txAddr[7:2]] = txWdata;
         if (owner == 0) begin
            if (fReq && dReq) grant = 3 - last;
            else if (dReq)    grant = 2;
            else if (fReq)    grant = 1;
            else              grant = 0;
         end else if (fin) begin
            grant = ((owner == 1) ? dReq : fReq) ? 3 - owner : 0;
         end else begin
            grant  = -1;
            waited = waited + 1;
         end
         if (grant > 0) begin
            owner  = grant;
            last   = grant;
            waited = 0;
            txAddr  = (grant == 2) ? dAddr : fAddr;
            txWe    = (grant == 2) ? dWe : 1'b0;
            txWdata = dWdata;
         end else if (grant == 0) begin
            owner = 0;
         end

         if (!fReq) begin
            if ($urandom_range(0, 2) != 0) begin fReq = 1'b1; fAddr = AW'($urandom_range(0, 63)) << 2; end
         end else if (expIfReady) begin
            fReq = ($urandom_range(0, 1) == 1); fAddr = AW'($urandom_range(0, 63)) << 2;
         end
         if (!dReq) begin
            if ($urandom_range(0, 2) != 0) begin
               dReq = 1'b1; dWe = ($urandom_range(0, 1) == 1);
               dAddr = AW'($urandom_range(0, 63)) << 2; dWdata = DW'($urandom());
            end
         end else if (expDmReady) begin
            dReq = ($urandom_range(0, 1) == 1); dWe = ($urandom_range(0, 1) == 1);
            dAddr = AW'($urandom_range(0, 63)) << 2; dWdata = DW'($urandom());
         end
      end
      nextCycle();
      idleInputs();
   endtask

   initial begin
      test_reset();
      test_fetch_only();
      test_store();
      test_contention();
      test_timeout();
      test_reset_mid_load();
      test_random(2000);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
